// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC_F, issues word fetches over a req/valid handshake and
// presents INSTR_F/PCPLUS4_F (or an all-ones bubble) to the fetch/decode register.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  S_BOOT  | first cycle after reset release, no request
//  S_FETCH | request outstanding at PC_F until IMEM_VALID
//  S_KILL  | redirected while a request was pending; drain and drop its data
//  S_HOLD  | instruction captured under stall; hold outputs, no request
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] BUBBLE   = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             STALL_F,
  input  logic             BRANCH_TAKEN_E,
  input  logic [WIDTH-1:0] BRANCH_TARGET_E,
  output logic             IMEM_REQ,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic             IMEM_VALID,
  input  logic [WIDTH-1:0] IMEM_RDATA,
  output logic [WIDTH-1:0] INSTR_F,
  output logic [WIDTH-1:0] PCPLUS4_F,
  output logic             INSTR_VALID_F,
  output logic [WIDTH-1:0] PC_F,
  output logic             FETCH_BUSY
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_KILL, S_HOLD} state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pcp4_q, pcp4_d;
  logic             ivalid_q, ivalid_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;

  assign pc_inc = pc_q + PC_STEP;
  assign target = BRANCH_TARGET_E & ALIGN_MASK;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= BUBBLE;
      pcp4_q   <= '0;
      ivalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcp4_q   <= pcp4_d;
      ivalid_q <= ivalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcp4_d   = pcp4_q;
    ivalid_d = ivalid_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (BRANCH_TAKEN_E) pc_d = target;
      end
      S_FETCH: begin
        if (BRANCH_TAKEN_E) begin
          pc_d     = target;
          instr_d  = BUBBLE;
          ivalid_d = 1'b0;
          // a still-pending response must be drained before reissuing
          if (!IMEM_VALID) state_d = S_KILL;
        end else if (IMEM_VALID) begin
          instr_d  = IMEM_RDATA;
          pcp4_d   = pc_inc;
          ivalid_d = 1'b1;
          pc_d     = pc_inc;
          if (STALL_F) state_d = S_HOLD;
        end else if (!STALL_F) begin
          instr_d  = BUBBLE;
          ivalid_d = 1'b0;
        end
      end
      S_KILL: begin
        if (BRANCH_TAKEN_E) pc_d = target;
        if (IMEM_VALID) state_d = S_FETCH;
      end
      S_HOLD: begin
        if (BRANCH_TAKEN_E) begin
          pc_d     = target;
          instr_d  = BUBBLE;
          ivalid_d = 1'b0;
          state_d  = S_FETCH;
        end else if (!STALL_F) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign IMEM_REQ      = (state_q == S_FETCH);
  assign IMEM_ADDR     = pc_q;
  assign FETCH_BUSY    = (state_q == S_BOOT) || (state_q == S_KILL) ||
                         ((state_q == S_FETCH) && !IMEM_VALID);
  assign INSTR_F       = instr_q;
  assign PCPLUS4_F     = pcp4_q;
  assign INSTR_VALID_F = ivalid_q;
  assign PC_F          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset PC 0 and FFFF_FFFC) share stimulus and
// are checked every cycle against a flag-based model, plus literal spot checks.
module tb_fetch_unit;

  localparam logic [31:0] BUB = 32'hFFFF_FFFF;

  logic        clk;
  logic        clr;
  logic        stall_f;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  logic        req, ivalid, busy;
  logic [31:0] addr, instr, pcp4, pc;
  logic        w_req, w_ivalid, w_busy;
  logic [31:0] w_addr, w_instr, w_pcp4, w_pc;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .CLR(clr), .STALL_F(stall_f), .BRANCH_TAKEN_E(branch_taken_e),
    .BRANCH_TARGET_E(branch_target_e), .IMEM_REQ(req), .IMEM_ADDR(addr),
    .IMEM_VALID(imem_valid), .IMEM_RDATA(imem_rdata), .INSTR_F(instr),
    .PCPLUS4_F(pcp4), .INSTR_VALID_F(ivalid), .PC_F(pc), .FETCH_BUSY(busy)
  );

  fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(clk), .CLR(clr), .STALL_F(stall_f), .BRANCH_TAKEN_E(branch_taken_e),
    .BRANCH_TARGET_E(branch_target_e), .IMEM_REQ(w_req), .IMEM_ADDR(w_addr),
    .IMEM_VALID(imem_valid), .IMEM_RDATA(imem_rdata), .INSTR_F(w_instr),
    .PCPLUS4_F(w_pcp4), .INSTR_VALID_F(w_ivalid), .PC_F(w_pc), .FETCH_BUSY(w_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        ivalid;
    logic        booting;
    logic        draining;
    logic        paused;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset(input logic [31:0] rpc);
    mdl_t s;
    s.pc = rpc; s.instr = BUB; s.pcp4 = 32'h0; s.ivalid = 1'b0;
    s.booting = 1'b1; s.draining = 1'b0; s.paused = 1'b0;
    return s;
  endfunction

  // one clock of the fetch rules: redirect beats stall beats advance
  function automatic mdl_t mstep(input mdl_t s, input bit stall, input bit br,
                                 input logic [31:0] tgt, input bit v, input logic [31:0] rd);
    mdl_t n = s;
    logic [31:0] aligned = {tgt[31:2], 2'b00};
    if (s.booting) begin
      n.booting = 1'b0;
      if (br) n.pc = aligned;
    end else if (s.draining) begin
      if (br) n.pc = aligned;
      if (v) n.draining = 1'b0;
    end else if (s.paused) begin
      if (br) begin
        n.pc = aligned; n.instr = BUB; n.ivalid = 1'b0; n.paused = 1'b0;
      end else if (!stall) n.paused = 1'b0;
    end else begin
      if (br) begin
        n.pc = aligned; n.instr = BUB; n.ivalid = 1'b0;
        n.draining = !v;
      end else if (v) begin
        n.instr = rd; n.pcp4 = s.pc + 32'd4; n.ivalid = 1'b1; n.pc = s.pc + 32'd4;
        n.paused = stall;
      end else if (!stall) begin
        n.instr = BUB; n.ivalid = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input logic r, input logic [31:0] a,
                          input logic [31:0] ins, input logic [31:0] p4, input logic iv,
                          input logic [31:0] p, input logic b);
    logic exp_req;
    logic exp_busy;
    exp_req  = !(m.booting || m.draining || m.paused);
    exp_busy = m.booting || m.draining || (exp_req && !imem_valid);
    chk({tag, "_instr"}, ins, m.instr);
    chk({tag, "_pcplus4"}, p4, m.pcp4);
    chk({tag, "_ivalid"}, {31'b0, iv}, {31'b0, m.ivalid});
    chk({tag, "_pc"}, p, m.pc);
    chk({tag, "_req"}, {31'b0, r}, {31'b0, exp_req});
    chk({tag, "_busy"}, {31'b0, b}, {31'b0, exp_busy});
    if (exp_req) chk({tag, "_addr"}, a, m.pc);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst("d0", m0, req, addr, instr, pcp4, ivalid, pc, busy);
      cmp_inst("dw", m1, w_req, w_addr, w_instr, w_pcp4, w_ivalid, w_pc, w_busy);
    end
  end

  task automatic cyc(input bit stall, input bit br, input logic [31:0] tgt,
                     input bit v, input logic [31:0] rd);
    stall_f = stall; branch_taken_e = br; branch_target_e = tgt;
    imem_valid = v; imem_rdata = rd;
    @(posedge clk);
    if (clr) begin
      m0 = mreset(32'h0000_0000);
      m1 = mreset(32'hFFFF_FFFC);
    end else begin
      m0 = mstep(m0, stall, br, tgt, v, rd);
      m1 = mstep(m1, stall, br, tgt, v, rd);
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    clr = 1'b1; stall_f = 1'b0; branch_taken_e = 1'b0; branch_target_e = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    m0 = mreset(32'h0000_0000);
    m1 = mreset(32'hFFFF_FFFC);
    chk_on = 1'b1;
    idle(); idle();
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);
    chk("rst_instr", instr, BUB);
    chk("rst_pcplus4", pcp4, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    clr = 1'b0;
    idle();
    chk("boot_req", {31'b0, req}, 32'd1);
    chk("boot_addr", addr, 32'h0);

    // streaming, one instruction per cycle
    cyc(0, 0, 0, 1, 32'hA0A0_0000);
    chk("s0_instr", instr, 32'hA0A0_0000);
    chk("s0_pcplus4", pcp4, 32'h4);
    chk("wrap_pcplus4", w_pcp4, 32'h0);
    chk("wrap_pc", w_pc, 32'h0);
    cyc(0, 0, 0, 1, 32'hA1A1_0001);
    chk("s1_pcplus4", pcp4, 32'h8);
    cyc(0, 0, 0, 1, 32'hA2A2_0002);
    chk("s2_instr", instr, 32'hA2A2_0002);
    chk("s2_pcplus4", pcp4, 32'hC);

    // stall on capture, held for several cycles
    cyc(1, 0, 0, 1, 32'hA3A3_0003);
    chk("hold_req", {31'b0, req}, 32'd0);
    repeat (3) cyc(1, 0, 0, 0, 32'h0);
    chk("hold_instr", instr, 32'hA3A3_0003);
    chk("hold_pcplus4", pcp4, 32'h10);
    idle();
    chk("release_req", {31'b0, req}, 32'd1);
    chk("release_addr", addr, 32'h10);
    chk("release_instr", instr, 32'hA3A3_0003);

    // wait states
    idle(); idle();
    chk("wait_instr", instr, BUB);
    chk("wait_ivalid", {31'b0, ivalid}, 32'd0);
    chk("wait_addr", addr, 32'h10);
    cyc(0, 0, 0, 1, 32'hA4A4_0004);
    chk("wait_done_instr", instr, 32'hA4A4_0004);
    chk("wait_done_pcplus4", pcp4, 32'h14);

    // redirect while a request is pending
    cyc(0, 1, 32'h103, 0, 32'h0);
    chk("kill_req", {31'b0, req}, 32'd0);
    chk("kill_pc", pc, 32'h100);
    idle();
    cyc(0, 0, 0, 1, 32'hDEAD_0001);
    chk("kill_drop_instr", instr, BUB);
    chk("kill_next_addr", addr, 32'h100);
    cyc(0, 0, 0, 1, 32'hA5A5_0005);
    chk("post_kill_pcplus4", pcp4, 32'h104);
    cyc(0, 1, 32'h40, 0, 32'h0);
    cyc(0, 1, 32'h81, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hDEAD_0002);
    chk("kill_latest_addr", addr, 32'h80);

    // redirect beats stall and valid
    cyc(1, 1, 32'h2002, 1, 32'hBEEF_0000);
    chk("simul_instr", instr, BUB);
    chk("simul_pc", pc, 32'h2000);
    chk("simul_req", {31'b0, req}, 32'd1);

    // redirect out of hold
    cyc(1, 0, 0, 1, 32'hA6A6_0006);
    cyc(1, 1, 32'h300, 0, 32'h0);
    chk("hold_br_instr", instr, BUB);
    chk("hold_br_pc", pc, 32'h300);

    // stall while waiting keeps the last instruction
    cyc(0, 0, 0, 1, 32'hA7A7_0007);
    cyc(1, 0, 0, 0, 32'h0);
    chk("stall_wait_instr", instr, 32'hA7A7_0007);
    chk("stall_wait_ivalid", {31'b0, ivalid}, 32'd1);
    cyc(0, 0, 0, 1, 32'hA8A8_0008);
    chk("stall_wait_next", pcp4, 32'h308);

    // wrap reached by redirect
    cyc(0, 1, 32'hFFFF_FFFF, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 1, 32'hA9A9_0009);
    chk("br_wrap_pcplus4", pcp4, 32'h0);
    chk("br_wrap_pc", pc, 32'h0);

    // asynchronous reset mid-cycle, late valid ignored
    imem_valid = 1'b1;
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_instr", instr, BUB);
    chk("async_ivalid", {31'b0, ivalid}, 32'd0);
    chk("async_req", {31'b0, req}, 32'd0);
    m0 = mreset(32'h0000_0000);
    m1 = mreset(32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 32'hBAD0_0000);
    clr = 1'b0;
    cyc(0, 0, 0, 1, 32'hBAD0_0001);
    chk("reboot_instr", instr, BUB);
    chk("reboot_req", {31'b0, req}, 32'd1);
    chk("reboot_addr", addr, 32'h0);
    cyc(0, 0, 0, 1, 32'hA0A0_0000);
    chk("reboot_first", instr, 32'hA0A0_0000);
    idle();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
